turn_timer: RTL and testbench

//  Per-turn countdown engine for the tic-tac-toe game; responder side of the FSM's reset_timer/finished handshake.

---
 rtl/turn_timer.sv | 137 +++++++++++++
 tb/tb_turn_timer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/turn_timer.sv
// Per-turn countdown engine for the tic-tac-toe game.
// A prescaler turns clk into a count tick. The turn counter runs 0..TURN_LIMIT
// while a player-turn state is active, pulses finished on expiry and restarts at 0.
// It also drives a hex 7-segment digit, a warning LED and a saturating expiry counter.
//
// Handshake with the game FSM:
//   reset_timer is a one-way synchronous clear request. It is honoured on the
//   cycle it is seen and needs no acknowledge.
//   finished is a one-cycle pulse. The FSM must act on it in that cycle; it is
//   never held.
//   After expiry the counter restarts by itself, so the FSM can change turns
//   on finished without asserting reset_timer.
module turn_timer #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int TURN_LIMIT = 15,
  parameter int WARN_AT    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reset_timer,
  input  logic [3:0] estado,
  input  logic       pause,
  output logic [3:0] count,
  output logic       tick,
  output logic       finished,
  output logic       warn,
  output logic       led_warn,
  output logic [6:0] seg,
  output logic [7:0] expiries
);

  localparam int              DW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(TICK_DIV - 1);
  localparam logic [DW-1:0]   DIV_HALF = DW'(TICK_DIV / 2);
  localparam logic [3:0]      LIMIT    = 4'(TURN_LIMIT);
  localparam logic [3:0]      WARN_LVL = 4'(WARN_AT);
  localparam logic [3:0]      TURNO_P1 = 4'b0010;
  localparam logic [3:0]      TURNO_P2 = 4'b0011;

  logic [DW-1:0] div_q, div_d;
  logic [3:0]    count_q, count_d;
  logic          tick_q, tick_d;
  logic          fin_q, fin_d;
  logic [7:0]    exp_q, exp_d;

  logic turn_state;
  logic run;
  logic wrap;

  // Count only in a turn state, and only when neither paused nor being cleared.
  always_comb begin
    turn_state = (estado == TURNO_P1) || (estado == TURNO_P2);
    run        = turn_state && !pause && !reset_timer;
    wrap       = run && (div_q == DIV_LAST);
  end

  // Next state: the clear wins over everything. A frozen timer holds its phase exactly.
  always_comb begin
    div_d   = div_q;
    count_d = count_q;
    tick_d  = 1'b0;
    fin_d   = 1'b0;
    exp_d   = exp_q;
    if (reset_timer) begin
      div_d   = '0;
      count_d = 4'd0;
    end else if (run) begin
      if (wrap) begin
        div_d  = '0;
        tick_d = 1'b1;
        if (count_q == LIMIT) begin
          count_d = 4'd0;
          fin_d   = 1'b1;
          if (exp_q != 8'hFF) exp_d = exp_q + 8'd1;
        end else begin
          count_d = count_q + 4'd1;
        end
      end else begin
        div_d = div_q + DW'(1);
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      count_q <= 4'd0;
      tick_q  <= 1'b0;
      fin_q   <= 1'b0;
      exp_q   <= 8'd0;
    end else begin
      div_q   <= div_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      fin_q   <= fin_d;
      exp_q   <= exp_d;
    end
  end

  // The warning comes straight from the registers, so it stays valid while paused.
  // The LED blinks during the first half of each tick period.
  always_comb begin
    warn     = turn_state && (count_q >= WARN_LVL);
    led_warn = warn && (div_q < DIV_HALF);
  end

  // Active-low hex decode of the count, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'h7F;
    case (count_q)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  assign count    = count_q;
  assign tick     = tick_q;
  assign finished = fin_q;
  assign expiries = exp_q;

endmodule

// File: tb/tb_turn_timer.sv
// Directed bench for turn_timer with TICK_DIV=4, TURN_LIMIT=15 and WARN_AT=12.
// A second instance with TURN_LIMIT=1 exercises expiry-counter saturation.
// Inputs change and outputs are sampled on the falling edge.
module tb_turn_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       reset_timer;
  logic [3:0] estado;
  logic       pause;
  logic [3:0] count;
  logic       tick, finished, warn, led_warn;
  logic [6:0] seg;
  logic [7:0] expiries;

  logic [3:0] s_count;
  logic       s_tick, s_finished, s_warn, s_led_warn;
  logic [6:0] s_seg;
  logic [7:0] s_expiries;

  int tests  = 0;
  int failed = 0;

  logic [6:0] seg_tab [16];
  logic [3:0] exp_q [$];

  // Clock and reset
  always #5 clk = ~clk;

  turn_timer #(.TICK_DIV(4), .TURN_LIMIT(15), .WARN_AT(12)) u_dut (
    .clk(clk), .rst(rst), .reset_timer(reset_timer), .estado(estado), .pause(pause),
    .count(count), .tick(tick), .finished(finished), .warn(warn), .led_warn(led_warn),
    .seg(seg), .expiries(expiries)
  );

  turn_timer #(.TICK_DIV(4), .TURN_LIMIT(1), .WARN_AT(1)) u_sat (
    .clk(clk), .rst(rst), .reset_timer(1'b0), .estado(4'b0010), .pause(1'b0),
    .count(s_count), .tick(s_tick), .finished(s_finished), .warn(s_warn),
    .led_warn(s_led_warn), .seg(s_seg), .expiries(s_expiries)
  );

  // Driver helpers
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    logic [3:0] ec;
    seg_tab[0]  = 7'h40; seg_tab[1]  = 7'h79; seg_tab[2]  = 7'h24; seg_tab[3]  = 7'h30;
    seg_tab[4]  = 7'h19; seg_tab[5]  = 7'h12; seg_tab[6]  = 7'h02; seg_tab[7]  = 7'h78;
    seg_tab[8]  = 7'h00; seg_tab[9]  = 7'h10; seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;

    rst = 1'b1; reset_timer = 1'b0; estado = 4'b0000; pause = 1'b0;
    step(3);
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_finished", finished, 0);
    check("rst_expiries", expiries, 0);
    check("rst_warn", warn, 0);
    check("rst_led_warn", led_warn, 0);
    check("rst_seg", seg, 7'h40);

    // Test 1: clear, then a full turn in TURNO_P1.
    rst = 1'b0; reset_timer = 1'b1; estado = 4'b0010;
    step(1);
    reset_timer = 1'b0;
    check("clr_count", count, 0);
    for (int i = 1; i <= 64; i++) exp_q.push_back(4'((i / 4) % 16));
    for (int i = 1; i <= 64; i++) begin
      step(1);
      ec = exp_q.pop_front();
      check("t1_count", count, ec);
      check("t1_tick", tick, (i % 4) == 0);
      check("t1_finished", finished, i == 64);
      check("t1_seg", seg, seg_tab[ec]);
      check("t1_warn", warn, ec >= 12);
      check("t1_led_warn", led_warn, (ec >= 12) && ((i % 4) < 2));
    end
    check("t1_expiries", expiries, 1);
    step(1);
    check("t1_fin_one_cycle", finished, 0);

    // Test 2: pause mid-period at count 5; the phase must survive.
    step(21);
    check("t2_pre_count", count, 5);
    pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t2_pause_count", count, 5);
      check("t2_pause_tick", tick, 0);
    end
    pause = 1'b0;
    step(1);
    check("t2_rel1_tick", tick, 0);
    check("t2_rel1_count", count, 5);
    step(1);
    check("t2_rel2_tick", tick, 1);
    check("t2_rel2_count", count, 6);

    // Test 4: leave the turn states at count 7; resume in TURNO_P2.
    step(4);
    check("t4_pre_count", count, 7);
    step(1);
    estado = 4'b0100;
    for (int i = 0; i < 50; i++) begin
      step(1);
      check("t4_hold_count", count, 7);
      check("t4_hold_tick", tick, 0);
    end
    estado = 4'b0011;
    step(2);
    check("t4_res2_tick", tick, 0);
    check("t4_res2_count", count, 7);
    step(1);
    check("t4_res3_tick", tick, 1);
    check("t4_res3_count", count, 8);

    // Test 6a: warning and blink in TURNO_P2 at count 12.
    step(16);
    check("t6_count12", count, 12);
    check("t6_warn", warn, 1);
    check("t6_led_ph0", led_warn, 1);
    step(1); check("t6_led_ph1", led_warn, 1);
    step(1); check("t6_led_ph2", led_warn, 0);
    step(1); check("t6_led_ph3", led_warn, 0);
    step(1); check("t6_count13", count, 13);
    pause = 1'b1;
    step(3);
    check("t6_warn_paused", warn, 1);
    pause = 1'b0;

    // Test 3: clear lands on the terminal wrap; the clear wins.
    step(11);
    check("t3_pre_count", count, 15);
    reset_timer = 1'b1;
    step(1);
    reset_timer = 1'b0;
    check("t3_count", count, 0);
    check("t3_finished", finished, 0);
    check("t3_tick", tick, 0);
    check("t3_expiries", expiries, 1);
    step(3);
    check("t3_phase_tick", tick, 0);
    step(1);
    check("t3_first_tick", tick, 1);
    check("t3_first_count", count, 1);

    // Test 5: asynchronous reset between edges at count 9.
    step(32);
    check("t5_pre_count", count, 9);
    #2 rst = 1'b1;
    #1;
    check("t5_count", count, 0);
    check("t5_tick", tick, 0);
    check("t5_finished", finished, 0);
    check("t5_expiries", expiries, 0);
    check("t5_warn", warn, 0);
    check("t5_led_warn", led_warn, 0);
    check("t5_seg", seg, 7'h40);

    // Test 6b: TURN_LIMIT=1 expires every 8 cycles; saturates at 255.
    step(1);
    rst = 1'b0;
    step(2032);
    check("sat_254", s_expiries, 254);
    step(8);
    check("sat_255", s_expiries, 255);
    check("sat_fin", s_finished, 1);
    step(8);
    check("sat_fin_after", s_finished, 1);
    check("sat_hold", s_expiries, 255);
    step(360);
    check("sat_hold_long", s_expiries, 255);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
